// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Fixed 34-cycle latency: 32 shift/iterate cycles, one sign-fix cycle, one done cycle.
module ex_muldiv_unit #(
   parameter int LATENCY_ITERS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        kill,
   input  logic [2:0]  funct3,
   input  logic [31:0] rs1_val,
   input  logic [31:0] rs2_val,
   input  logic [4:0]  rd,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [4:0]  rd_out
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t      state, next_state;
   logic [2:0]  op;
   logic [4:0]  rd_q;
   logic [31:0] addend;
   logic [31:0] raw_a;
   logic        neg_res, divz, ovf;
   logic [5:0]  cnt;
   logic [63:0] acc;

   logic        a_signed, b_signed, sign_a, sign_b, is_div, accept;
   logic [31:0] abs_a, abs_b;
   logic [32:0] mul_sum, div_shift, div_diff;
   logic        div_ge;
   logic [63:0] mul_next, div_next, prod_fix;
   logic [31:0] quo_fix, rem_fix, fix_val;

   // Operand decode: magnitudes and result sign are captured once at accept time.
   always_comb begin
      a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b110);
      b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
      sign_a   = a_signed & rs1_val[31];
      sign_b   = b_signed & rs2_val[31];
      abs_a    = sign_a ? (~rs1_val + 32'd1) : rs1_val;
      abs_b    = sign_b ? (~rs2_val + 32'd1) : rs2_val;
      is_div   = funct3[2];
      accept   = (state == IDLE) && start && !kill;
   end

   // Multiply keeps the multiplier in acc[31:0]; divide keeps {remainder, quotient} in acc.
   always_comb begin
      mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, addend} : 33'd0);
      mul_next  = {mul_sum, acc[31:1]};
      div_shift = {acc[63:32], acc[31]};
      div_diff  = div_shift - {1'b0, addend};
      div_ge    = ~div_diff[32];
      div_next  = {(div_ge ? div_diff[31:0] : div_shift[31:0]), acc[30:0], div_ge};
   end

   // Sign correction and result select; divide-by-zero and overflow override the sign fix.
   always_comb begin
      prod_fix = neg_res ? (~acc + 64'd1) : acc;
      quo_fix  = neg_res ? (~acc[31:0] + 32'd1) : acc[31:0];
      rem_fix  = neg_res ? (~acc[63:32] + 32'd1) : acc[63:32];
      fix_val  = 32'd0;
      case (op)
         3'b000:                 fix_val = prod_fix[31:0];
         3'b001, 3'b010, 3'b011: fix_val = prod_fix[63:32];
         3'b100, 3'b101:         fix_val = divz ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : quo_fix);
         default:                fix_val = divz ? raw_a : (ovf ? 32'd0 : rem_fix);
      endcase
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (start && !kill) next_state = CALC;
         CALC: begin
            if (kill)                                 next_state = IDLE;
            else if (cnt == 6'(LATENCY_ITERS - 1))    next_state = FIX;
         end
         FIX:  next_state = kill ? IDLE : DONE;
         DONE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= next_state;
         busy  <= (next_state != IDLE);
         done  <= (next_state == DONE);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op      <= 3'd0;
         rd_q    <= 5'd0;
         addend  <= 32'd0;
         raw_a   <= 32'd0;
         neg_res <= 1'b0;
         divz    <= 1'b0;
         ovf     <= 1'b0;
         cnt     <= 6'd0;
         acc     <= 64'd0;
         result  <= 32'd0;
         rd_out  <= 5'd0;
      end else if (accept) begin
         op      <= funct3;
         rd_q    <= rd;
         addend  <= is_div ? abs_b : abs_a;
         acc     <= is_div ? {32'd0, abs_a} : {32'd0, abs_b};
         raw_a   <= rs1_val;
         neg_res <= (is_div && funct3[1]) ? sign_a : (sign_a ^ sign_b);
         divz    <= is_div && (rs2_val == 32'd0);
         ovf     <= is_div && !funct3[0] && (rs1_val == 32'h8000_0000) &&
                    (rs2_val == 32'hFFFF_FFFF);
         cnt     <= 6'd0;
      end else if (state == CALC) begin
         cnt <= cnt + 6'd1;
         acc <= op[2] ? div_next : mul_next;
      end else if (state == FIX && !kill) begin
         result <= fix_val;
         rd_out <= rd_q;
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: vector table plus control-path sequences,
// with a scoreboard queue matching each completion against value, rd and cycle.
module tb_ex_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst, start, kill;
   logic [2:0]  funct3;
   logic [31:0] rs1_val, rs2_val;
   logic [4:0]  rd;
   logic        busy, done;
   logic [31:0] result;
   logic [4:0]  rd_out;

   ex_muldiv_unit dut (
      .clk(clk), .rst(rst), .start(start), .kill(kill), .funct3(funct3),
      .rs1_val(rs1_val), .rs2_val(rs2_val), .rd(rd),
      .busy(busy), .done(done), .result(result), .rd_out(rd_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      int          due;
   } exp_t;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] res;
   } vec_t;

   exp_t        sb_q[$];
   vec_t        tbl[22];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_result = 32'd0;
   int          t0;

   // Independent reference using 64-bit host arithmetic.
   function automatic logic [31:0] modelResult(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] pv;
      logic [31:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      r  = 32'd0;
      case (f3)
         3'd0: begin pv = ua * ub; r = pv[31:0];  end
         3'd1: begin pv = sa * sb; r = pv[63:32]; end
         3'd2: begin pv = sa * ub; r = pv[63:32]; end
         3'd3: begin pv = ua * ub; r = pv[63:32]; end
         3'd4: begin
            if (b == 32'd0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
            else begin pv = sa / sb; r = pv[31:0]; end
         end
         3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 32'd0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
            else begin pv = sa % sb; r = pv[31:0]; end
         end
         default: r = (b == 32'd0) ? a : a % b;
      endcase
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h cycle=%0d", name, actual, expected, cyc);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] r, input logic [31:0] res, input bit push);
      @(negedge clk);
      funct3 = f3; rs1_val = a; rs2_val = b; rd = r; start = 1'b1;
      if (push) begin
         sb_q.push_back('{res, r, cyc + 34});
         last_result = res;
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitDrain();
      int n = 0;
      while (sb_q.size() != 0 && n < 45) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL done_timeout actual=none expected=done pending=%0d", sb_q.size());
         sb_q.delete();
      end
   endtask

   // Completion monitor: every done must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (done === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_done actual=1 expected=0 cycle=%0d", cyc);
         end else begin
            e = sb_q.pop_front();
            checkOutput("result", result, e.res);
            checkOutput("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
            checkOutput("done_cycle", 32'(cyc), 32'(e.due));
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      tbl[0]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000};
      tbl[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE};
      tbl[2]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF};
      tbl[3]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFD};
      tbl[4]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd5,  32'hFFFF_FFFF};
      tbl[5]  = '{3'd5, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'h7FFF_FFFC};
      tbl[6]  = '{3'd7, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'd1};
      tbl[7]  = '{3'd4, 32'd5,         32'd0,         5'd8,  32'hFFFF_FFFF};
      tbl[8]  = '{3'd7, 32'd5,         32'd0,         5'd10, 32'd5};
      tbl[9]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000};
      tbl[10] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0};
      tbl[11] = '{3'd6, 32'hFFFF_FFFB, 32'd0,         5'd13, 32'hFFFF_FFFB};
      tbl[12] = '{3'd4, 32'd7,         32'hFFFF_FFFE, 5'd14, 32'hFFFF_FFFD};
      tbl[13] = '{3'd1, 32'hFFFF_FFFF, 32'd1,         5'd15, 32'hFFFF_FFFF};
      for (int i = 14; i < 22; i++) begin
         tbl[i].f3 = 3'($urandom_range(0, 7));
         tbl[i].a  = $urandom;
         tbl[i].b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
         tbl[i].rd = 5'($urandom_range(1, 31));
         tbl[i].res = modelResult(tbl[i].f3, tbl[i].a, tbl[i].b);
      end

      rst = 1'b0; start = 1'b0; kill = 1'b0;
      funct3 = 3'd0; rs1_val = 32'd0; rs2_val = 32'd0; rd = 5'd0;
      #1;
      checkOutput("reset_busy",   {31'd0, busy}, 32'd0);
      checkOutput("reset_done",   {31'd0, done}, 32'd0);
      checkOutput("reset_result", result,        32'd0);
      checkOutput("reset_rd_out", {27'd0, rd_out}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // MUL with full busy trace across the 34-cycle window.
      applyStimulus(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, 32'hFFFF_FFEB, 1'b1);
      for (int k = 1; k <= 35; k++) begin
         checkOutput($sformatf("busy_T+%0d", k), {31'd0, busy}, (k <= 34) ? 32'd1 : 32'd0);
         if (k < 35) @(negedge clk);
      end
      waitDrain();

      for (int i = 0; i < 22; i++) begin
         applyStimulus(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].res, 1'b1);
         waitDrain();
      end

      // Kill at T+10, restart at T+11, stray start five cycles into the new op.
      applyStimulus(3'd0, 32'd3, 32'd4, 5'd3, 32'd12, 1'b1);
      waitDrain();
      applyStimulus(3'd4, 32'd100, 32'd7, 5'd4, 32'd0, 1'b0);
      repeat (9) @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      checkOutput("kill_busy", {31'd0, busy}, 32'd0);
      checkOutput("kill_result_held", result, last_result);
      funct3 = 3'd5; rs1_val = 32'd100; rs2_val = 32'd7; rd = 5'd17; start = 1'b1;
      sb_q.push_back('{32'd14, 5'd17, cyc + 34});
      last_result = 32'd14;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      funct3 = 3'd0; rs1_val = 32'd1; rs2_val = 32'd1; rd = 5'd30; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitDrain();

      // Kill and start together in IDLE: request dropped.
      @(negedge clk);
      funct3 = 3'd0; rs1_val = 32'd2; rs2_val = 32'd2; rd = 5'd5; start = 1'b1; kill = 1'b1;
      @(negedge clk);
      start = 1'b0; kill = 1'b0;
      checkOutput("kill_start_busy", {31'd0, busy}, 32'd0);
      repeat (40) @(negedge clk);

      // Kill during DONE: done still reported, unit idle afterwards.
      applyStimulus(3'd3, 32'hFFFF_FFFF, 32'd2, 5'd21, 32'd1, 1'b1);
      repeat (33) @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      checkOutput("kill_done_busy", {31'd0, busy}, 32'd0);
      checkOutput("kill_done_result", result, 32'd1);
      waitDrain();

      // Asynchronous reset mid-CALC.
      applyStimulus(3'd0, 32'd11, 32'd13, 5'd22, 32'd0, 1'b0);
      repeat (19) @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("midreset_busy",   {31'd0, busy}, 32'd0);
      checkOutput("midreset_done",   {31'd0, done}, 32'd0);
      checkOutput("midreset_result", result,        32'd0);
      checkOutput("midreset_rd_out", {27'd0, rd_out}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (40) @(negedge clk);
      applyStimulus(3'd0, 32'd11, 32'd13, 5'd23, 32'd143, 1'b1);
      waitDrain();
      @(negedge clk);
      checkOutput("post_reset_busy", {31'd0, busy}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
